inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Decoupled instruction-fetch stage for the next-generation core: replaces the direct pc -> inst_ram1 path.
//  Issues pipelined requests to instruction memory and buffers returned words with their PC in a DEPTH-entry prefetch queue.
//  Presents instructions to decode through a valid/ready handshake.
//  Taken branches and jumps redirect it; stale queue entries and in-flight responses are squashed.
// PARAMETERS
//  RESET_PC         32'h0000_0000  fetch address after reset
//  DEPTH            4              prefetch queue entries (power of 2, >=2)
//  MAX_OUTSTANDING  2              max accepted-but-unanswered memory requests (>=1, <=DEPTH)
// PORTS
//  clk              in   1   sole clock, rising edge
//  rst_n            in   1   reset, asynchronous assert, active-low
//  o_imem_req       out  1   request valid to instruction memory
//  o_imem_addr      out  32  word-aligned request address (fetch_pc)
//  i_imem_gnt       in   1   request accepted this cycle (req & gnt = handshake)
//  i_imem_rvalid    in   1   read data valid; in order, exactly one per granted request, >=1 cycle after grant
//  i_imem_rdata     in   32  instruction word
//  i_redirect       in   1   branch/jump taken (from branch unit br_is_branching)
//  i_redirect_addr  in   32  redirect target
//  o_inst_valid     out  1   queue head valid
//  o_inst_data      out  32  queue head instruction
//  o_inst_pc        out  32  PC of queue head
//  i_inst_ready     in   1   decode consumes head (valid & ready = pop)
//  o_fetch_misaligned out 1  sticky: last redirect target had addr[1:0]!=0
// BEHAVIOUR
//  Reset (async, rst_n=0): fetch_pc=RESET_PC, resp_pc=RESET_PC, queue empty, outstanding=0, discard=0,
//   o_imem_req=0, o_inst_valid=0, o_inst_data=0, o_inst_pc=0, o_fetch_misaligned=0. Reset mid-transfer drops everything;
//   memory responses arriving while rst_n=0 are ignored.
//  Credit rule: o_imem_req = !i_redirect & !misaligned & (count+outstanding < DEPTH) & (outstanding < MAX_OUTSTANDING).
//   o_imem_req is combinational; the queue can never overflow.
//  Grant: req&gnt -> fetch_pc += 4 (32-bit wrap from 32'hFFFF_FFFC to 0 permitted), outstanding += 1.
//  Response: rvalid -> outstanding -= 1; grant and rvalid in the same cycle leave outstanding unchanged.
//   If discard>0: word dropped, discard -= 1.
//   Otherwise: {rdata, resp_pc} pushed to queue, resp_pc += 4.
//  Latency: rvalid at cycle N -> o_inst_valid at N+1; no bypass. Best case is grant N, rvalid N+1, visible N+2.
//  Pop: valid&ready removes head. Push and pop in the same cycle keep count; push and pop on a full queue are legal.
//   Head outputs hold stable while valid & !ready.
//  Redirect (i_redirect=1, highest priority):
//   - queue flushed next cycle: o_inst_valid=0; any pop in the same cycle is ignored;
//   - fetch_pc <= {addr[31:2],2'b00}, resp_pc <= same;
//   - discard <= outstanding - rvalid; all in-flight words are stale, including one returning this cycle, which is dropped;
//   - addr[1:0]!=0 -> o_fetch_misaligned=1, requests halt until the next aligned redirect, which clears the flag.
//  Back-to-back redirects: the last one wins; the discard recompute still covers all in-flight words.
//  Queue empty & ready: no pop, o_inst_data holds the last value.
// STRUCTURE
//  GLOBALS.v gains `RESET_VECTOR (default for RESET_PC) and `IFU_DEPTH; no new typedefs.
//  Sub-module sync_fifo #(WIDTH=64, DEPTH): push/pop/flush, count output, registered head. It is reused by later LSU work.
//  Top holds fetch_pc, resp_pc, outstanding and discard counters ($clog2(MAX_OUTSTANDING+1) bits), credit logic, misaligned flag.
// TESTING
//  1 Reset, zero-wait memory (gnt=1, rvalid 1 cycle later), ready=1 -> PCs 0,4,8,... one instr/cycle after a 2-cycle fill.
//  2 ready=0 for 10 cycles, DEPTH=4 -> exactly 4 grants then req=0; ready=1 -> words popped in order, req resumes.
//  3 Two requests outstanding (0x10, 0x14), redirect to 0x200 -> both responses dropped; next o_inst_pc=0x200.
//  4 Redirect in the same cycle as rvalid and a pop -> no push, no pop; queue empty next cycle; discard accounting exact.
//  5 Redirect to 0x102 -> o_fetch_misaligned=1, req=0 thereafter; redirect to 0x100 -> flag clears, fetch resumes at 0x100.
//  6 rst_n low with 2 in flight and queue full -> all outputs 0 immediately; after release fetch restarts at RESET_PC.
//  Random gnt/rvalid/ready/redirect soak against a reference PC model; assert no overflow and in-order delivery.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit.
//   RESET_VECTOR : default fetch address after reset
//   IFU_DEPTH    : default prefetch queue depth
//   ifu_entry_t  : one queued word, instruction plus the PC it was fetched from
//   align_word() : clears the byte-offset bits of an address
package inst_fetch_unit_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam int          IFU_DEPTH    = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } ifu_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_sync_fifo.sv
// Synchronous FIFO with push/pop/flush, occupancy count and a registered head.
// The head register keeps its last value when the FIFO drains or is flushed.
//   clk, rst_n : clock, async active-low reset
//   push       : write push_data (ignored when full unless popping too)
//   push_data  : WIDTH-bit entry
//   pop        : remove head (ignored when empty)
//   flush      : empty the FIFO; overrides push and pop
//   valid      : FIFO not empty
//   head       : oldest entry
//   count      : number of stored entries
module inst_fetch_unit_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       valid,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    remaining;

    assign full       = (count == CW'(DEPTH));
    assign do_pop     = pop & (count != '0) & ~flush;
    assign do_push    = push & (~full | do_pop) & ~flush;
    assign rd_ptr_nxt = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    // entries left once this cycle's pop is taken, before this cycle's push
    assign remaining  = count - CW'(do_pop);
    assign valid      = (count != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= remaining + CW'(do_push);
            // If older entries remain, the new head is already in memory;
            // otherwise a word pushed into an empty slot becomes the head.
            if (remaining != '0) begin
                head <= mem[rd_ptr_nxt];
            end else if (do_push) begin
                head <= push_data;
            end
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Decoupled instruction-fetch stage. Issues pipelined requests to instruction
// memory, buffers returned words with their PC in a prefetch queue and hands
// them to decode over valid/ready. A redirect flushes the queue and marks
// every in-flight response as stale.
//   clk, rst_n         : clock, async active-low reset
//   o_imem_req/addr    : memory request and word-aligned fetch address
//   i_imem_gnt         : request accepted this cycle
//   i_imem_rvalid/rdata: in-order read response
//   i_redirect/_addr   : taken branch/jump and its target
//   o_inst_valid/data/pc, i_inst_ready : decode handshake, queue head
//   o_fetch_misaligned : sticky, last redirect target was not word aligned
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_VECTOR,
    parameter int          DEPTH           = IFU_DEPTH,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_addr,
    output logic        o_inst_valid,
    output logic [31:0] o_inst_data,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready,
    output logic        o_fetch_misaligned
);

    localparam int OW = $clog2(MAX_OUTSTANDING+1);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard;
    logic          misaligned;
    logic          credit_ok;
    logic          grant;
    logic          push;
    logic          pop;
    logic [CW-1:0] fifo_count;
    ifu_entry_t    push_entry;
    ifu_entry_t    head_entry;
    logic [63:0]   head_bits;

    // Queued words plus words still in flight never exceed the queue depth,
    // so every response is guaranteed a slot.
    assign credit_ok = ((32'(fifo_count) + 32'(outstanding)) < 32'(DEPTH)) &&
                       (32'(outstanding) < 32'(MAX_OUTSTANDING));

    assign o_imem_req  = rst_n & ~i_redirect & ~misaligned & credit_ok;
    assign o_imem_addr = fetch_pc;
    assign grant       = o_imem_req & i_imem_gnt;
    assign push        = i_imem_rvalid & (discard == '0) & ~i_redirect;
    assign pop         = i_inst_ready & o_inst_valid & ~i_redirect;

    assign push_entry = '{data: i_imem_rdata, pc: resp_pc};
    assign head_entry = ifu_entry_t'(head_bits);

    assign o_inst_data        = head_entry.data;
    assign o_inst_pc          = head_entry.pc;
    assign o_fetch_misaligned = misaligned;

    inst_fetch_unit_sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (i_redirect),
        .valid     (o_inst_valid),
        .head      (head_bits),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            misaligned  <= 1'b0;
        end else if (i_redirect) begin
            fetch_pc    <= align_word(i_redirect_addr);
            resp_pc     <= align_word(i_redirect_addr);
            // No grant can happen during a redirect; everything still in
            // flight after this cycle's response is stale.
            outstanding <= outstanding - OW'(i_imem_rvalid);
            discard     <= outstanding - OW'(i_imem_rvalid);
            misaligned  <= |i_redirect_addr[1:0];
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (grant && !i_imem_rvalid) begin
                outstanding <= outstanding + OW'(1);
            end else if (!grant && i_imem_rvalid) begin
                outstanding <= outstanding - OW'(1);
            end
            if (i_imem_rvalid) begin
                if (discard != '0) begin
                    discard <= discard - OW'(1);
                end else begin
                    resp_pc <= resp_pc + 32'd4;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_addr = '0;
    logic        o_inst_valid;
    logic [31:0] o_inst_data;
    logic [31:0] o_inst_pc;
    logic        i_inst_ready = 1'b0;
    logic        o_fetch_misaligned;

    inst_fetch_unit #(
        .RESET_PC        (RPC),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .o_imem_req         (o_imem_req),
        .o_imem_addr        (o_imem_addr),
        .i_imem_gnt         (i_imem_gnt),
        .i_imem_rvalid      (i_imem_rvalid),
        .i_imem_rdata       (i_imem_rdata),
        .i_redirect         (i_redirect),
        .i_redirect_addr    (i_redirect_addr),
        .o_inst_valid       (o_inst_valid),
        .o_inst_data        (o_inst_data),
        .o_inst_pc          (o_inst_pc),
        .i_inst_ready       (i_inst_ready),
        .o_fetch_misaligned (o_fetch_misaligned)
    );

    always #5 clk = ~clk;

    // in-flight request as seen by the memory; stale once a redirect passes it
    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          gcyc;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } word_t;

    req_t        pend[$];
    word_t       mq[$];
    word_t       hold;
    logic [31:0] m_fetch;
    bit          m_mis;

    int cyc, grants, pops;
    int n_checks, n_fail;
    int p_gnt, p_rv, p_rdy, p_redir;
    bit force_redir;
    logic [31:0] force_addr;
    bit d_gnt, d_rv, d_rdy, d_redir, exp_req;
    logic [31:0] d_raddr;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        mq.delete();
        hold    = '{pc: '0, data: '0};
        m_fetch = RPC;
        m_mis   = 1'b0;
    endtask

    task automatic do_reset();
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_redirect    = 1'b0;
        i_inst_ready  = 1'b0;
        rst_n         = 1'b0;
        #1;
        chk("rst_req", o_imem_req, 0);
        chk("rst_valid", o_inst_valid, 0);
        chk("rst_data", o_inst_data, 0);
        chk("rst_pc", o_inst_pc, 0);
        chk("rst_mis", o_fetch_misaligned, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: drive random inputs, check outputs against the model,
    // then advance the model by what happened at the rising edge.
    task automatic step();
        int    sel;
        req_t  r;
        @(negedge clk);
        sel = $urandom_range(0, 99);
        if (force_redir) d_raddr = force_addr;
        else if (sel < 20) d_raddr = $urandom & 32'h0000_0FFF;
        else if (sel < 30) d_raddr = 32'hFFFF_FFF0;
        else d_raddr = $urandom & 32'h0000_3FFC;
        d_redir = force_redir || ($urandom_range(0, 99) < p_redir);
        force_redir = 1'b0;
        d_gnt = ($urandom_range(0, 99) < p_gnt);
        d_rv  = (pend.size() > 0) && (pend[0].gcyc < cyc) && ($urandom_range(0, 99) < p_rv);
        d_rdy = ($urandom_range(0, 99) < p_rdy);
        i_redirect      = d_redir;
        i_redirect_addr = d_raddr;
        i_imem_gnt      = d_gnt;
        i_imem_rvalid   = d_rv;
        i_imem_rdata    = d_rv ? word_of(pend[0].addr) : $urandom;
        i_inst_ready    = d_rdy;
        exp_req = !d_redir && !m_mis && ((mq.size() + pend.size()) < DEPTH) && (pend.size() < MAXO);
        #1;
        chk("req", o_imem_req, exp_req);
        if (exp_req) chk("addr", o_imem_addr, m_fetch);
        chk("valid", o_inst_valid, mq.size() != 0);
        if (mq.size() != 0) hold = mq[0];
        chk("inst_pc", o_inst_pc, hold.pc);
        chk("inst_data", o_inst_data, hold.data);
        chk("misaligned", o_fetch_misaligned, m_mis);
        @(posedge clk);
        if (d_redir) begin
            if (d_rv) void'(pend.pop_front());
            foreach (pend[i]) pend[i].stale = 1'b1;
            mq.delete();
            m_fetch = {d_raddr[31:2], 2'b00};
            m_mis   = (d_raddr[1:0] != 2'b00);
        end else begin
            if (d_rdy && mq.size() != 0) begin
                void'(mq.pop_front());
                pops++;
            end
            if (d_rv) begin
                r = pend.pop_front();
                if (!r.stale) mq.push_back('{pc: r.addr, data: word_of(r.addr)});
            end
            if (exp_req && d_gnt) begin
                pend.push_back('{addr: m_fetch, stale: 1'b0, gcyc: cyc});
                m_fetch = m_fetch + 32'd4;
                grants++;
            end
        end
        cyc++;
    endtask

    task automatic set_knobs(input int g, input int rv, input int rdy, input int rd);
        p_gnt = g; p_rv = rv; p_rdy = rdy; p_redir = rd;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        force_redir = 1'b1;
        force_addr  = a;
        step();
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        #1;
        while (!o_inst_valid && k < 30) begin
            step();
            #1;
            k++;
        end
        chk(tag, o_inst_valid, 1);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; grants = 0; pops = 0;
        force_redir = 1'b0; force_addr = '0;
        model_reset();
        set_knobs(0, 0, 0, 0);
        do_reset();

        // zero-wait memory, decode always ready: one instruction per cycle
        set_knobs(100, 100, 100, 0);
        grants = 0; pops = 0;
        repeat (20) step();
        chk("t1_pops", pops, 18);

        // decode stalled: exactly DEPTH grants, then resume in order
        do_reset();
        set_knobs(100, 100, 0, 0);
        grants = 0;
        repeat (10) step();
        chk("t2_grants", grants, DEPTH);
        #1;
        chk("t2_req_stall", o_imem_req, 0);
        p_rdy = 100;
        repeat (10) step();
        chk("t2_resume", grants > DEPTH, 1);

        // two requests in flight, redirect drops both responses
        do_reset();
        set_knobs(100, 0, 100, 0);
        redirect_to(32'h10);
        repeat (2) step();
        redirect_to(32'h200);
        p_rv = 100;
        wait_valid("t3_valid");
        chk("t3_first_pc", o_inst_pc, 32'h200);

        // misaligned redirect halts fetch until an aligned one
        set_knobs(100, 100, 100, 0);
        redirect_to(32'h102);
        grants = 0;
        repeat (6) step();
        chk("t5_grants", grants, 0);
        chk("t5_flag", o_fetch_misaligned, 1);
        redirect_to(32'h100);
        wait_valid("t5_valid");
        chk("t5_first_pc", o_inst_pc, 32'h100);
        chk("t5_flag_clr", o_fetch_misaligned, 0);

        // random soak
        set_knobs(60, 60, 60, 4);
        repeat (3000) step();

        // reset with requests in flight
        set_knobs(100, 0, 0, 0);
        redirect_to(32'h40);
        for (int k = 0; k < 10 && pend.size() < MAXO; k++) step();
        chk("t6_inflight", pend.size(), MAXO);
        #3;
        rst_n         = 1'b0;
        i_imem_rvalid = 1'b1;
        #1;
        chk("t6_req", o_imem_req, 0);
        chk("t6_valid", o_inst_valid, 0);
        chk("t6_data", o_inst_data, 0);
        chk("t6_pc", o_inst_pc, 0);
        chk("t6_mis", o_fetch_misaligned, 0);
        do_reset();
        #1;
        chk("t6_restart", o_imem_addr, RPC);
        set_knobs(100, 100, 100, 0);
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
